// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry registered skid buffer for adder results with Z/N/C/V flags and overflow statistics
module alu_result_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] sum,
  input  logic                  c_out,
  input  logic                  overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [3:0]            out_flags,
  output logic                  ovf_sticky,
  output logic [CNT_WIDTH-1:0]  ovf_count,
  input  logic                  stat_clear
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] tail_result;
  logic [3:0]            tail_flags;
  logic [3:0]            in_flags;
  logic                  accept;
  logic                  pop;
  // Flags are captured with the entry; a result zeroed by overflow is not reported as zero
  always_comb begin
    accept   = in_valid & in_ready;
    pop      = out_valid & out_ready;
    in_flags = {(sum == '0) & ~overflow, sum[DATA_WIDTH-1], c_out, overflow};
  end
  // Occupancy FSM; the head slot drives out_* directly, and in_ready/out_valid track the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_flags   <= '0;
      tail_result <= '0;
      tail_flags  <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          out_result <= sum;
          out_flags  <= in_flags;
          out_valid  <= 1'b1;
          state      <= ONE;
        end
        ONE: if (accept && !pop) begin
          tail_result <= sum;
          tail_flags  <= in_flags;
          in_ready    <= 1'b0;
          state       <= FULL;
        end else if (accept) begin
          out_result <= sum;
          out_flags  <= in_flags;
        end else if (pop) begin
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
        FULL: if (pop) begin
          out_result <= tail_result;
          out_flags  <= tail_flags;
          in_ready   <= 1'b1;
          state      <= ONE;
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
  // Overflow statistics; clear wins over a same-cycle overflow, count saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clear) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (accept && overflow) begin
      ovf_sticky <= 1'b1;
      ovf_count  <= (&ovf_count) ? ovf_count : ovf_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard bench driving modelled adder results through alu_result_stage
module tb_alu_result_stage;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, out_ready, stat_clear, c_out, overflow;
  logic [7:0] sum;
  logic       in_ready, out_valid, ovf_sticky;
  logic [7:0] out_result, ovf_count;
  logic [3:0] out_flags;
  int         checks = 0;
  int         errors = 0;
  logic [11:0] q[$];
  bit         m_sticky = 0;
  int         m_count = 0;

  alu_result_stage #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .stat_clear(stat_clear)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [3:0] exp_flags(logic [7:0] s, logic c, logic v);
    return {(s == 8'h00) && !v, s[7], c, v};
  endfunction

  // Behaviour of the upstream 8-bit adder: signed overflow forces the sum to zero
  task automatic drive_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    bit v;
    s = {1'b0, a} + {1'b0, b};
    v = (a[7] == b[7]) && (s[7] != a[7]);
    sum = v ? 8'h00 : s[7:0];
    c_out = s[8];
    overflow = v;
  endtask

  // One clock with the current drive; updates the reference model for what the edge did
  task automatic step(output bit acc);
    bit rl, clr;
    @(negedge clk);
    acc = rst_n && in_valid && in_ready;
    rl  = !rst_n;
    clr = stat_clear;
    @(posedge clk);
    #1;
    if (rl) begin
      q.delete();
      m_sticky = 0;
      m_count  = 0;
    end else begin
      if (acc) q.push_back({sum, exp_flags(sum, c_out, overflow)});
      if (clr) begin
        m_sticky = 0;
        m_count  = 0;
      end else if (acc && overflow) begin
        m_sticky = 1;
        if (m_count < 255) m_count++;
      end
    end
  endtask

  // Monitor: occupancy, statistics and in-order delivery against the scoreboard queue
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("ovf_sticky", ovf_sticky, m_sticky);
      chk("ovf_count", ovf_count, m_count);
      if (out_valid && out_ready && q.size() > 0) begin
        logic [11:0] e;
        e = q.pop_front();
        chk("out_result", out_result, e[11:4]);
        chk("out_flags", out_flags, e[3:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit a;
    int n;
    in_valid = 0; out_ready = 0; stat_clear = 0; sum = 0; c_out = 0; overflow = 0;
    repeat (2) step(a);
    rst_n = 1;
    chk("reset out_result", out_result, 0);
    chk("reset out_flags", out_flags, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    // single entry, one-cycle latency
    in_valid = 1; sum = 8'h80; out_ready = 1;
    step(a);
    in_valid = 0;
    chk("lat out_valid", out_valid, 1);
    chk("lat out_result", out_result, 8'h80);
    chk("lat out_flags", out_flags, 4'b0100);
    step(a);
    chk("lat drained", out_valid, 0);
    // overflow and carry flag cases
    in_valid = 1; drive_add(8'h7F, 8'h01);
    step(a);
    chk("ovf flags", out_flags, 4'b0001);
    chk("ovf sticky", ovf_sticky, 1);
    chk("ovf count", ovf_count, 1);
    drive_add(8'hFF, 8'h01);
    step(a);
    chk("carry flags", out_flags, 4'b1010);
    in_valid = 0;
    repeat (2) step(a);
    // back-pressure: third offer held off while full
    out_ready = 0; in_valid = 1; c_out = 0; overflow = 0;
    sum = 8'h11; step(a); chk("acc 0x11", a, 1);
    sum = 8'h22; step(a); chk("acc 0x22", a, 1);
    sum = 8'h33; step(a); chk("hold 0x33", a, 0);
    chk("full in_ready", in_ready, 0);
    out_ready = 1;
    n = 0;
    do begin step(a); n++; end while (!a && n < 10);
    chk("acc 0x33", a, 1);
    in_valid = 0;
    repeat (4) step(a);
    // steady ONE with accept and release every cycle
    out_ready = 0; in_valid = 1; sum = 8'hA0;
    step(a);
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      drive_add(8'($urandom), 8'($urandom));
      step(a);
      chk("stream accept", a, 1);
    end
    in_valid = 0;
    repeat (3) step(a);
    // saturation of overflow counter, then clear against a concurrent overflow
    in_valid = 1; drive_add(8'h80, 8'h80);
    repeat (300) step(a);
    chk("sat count", ovf_count, 255);
    stat_clear = 1;
    step(a);
    stat_clear = 0;
    chk("clear count", ovf_count, 0);
    chk("clear sticky", ovf_sticky, 0);
    in_valid = 0;
    repeat (3) step(a);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      stat_clear = ($urandom_range(0, 31) == 0);
      drive_add(8'($urandom), 8'($urandom));
      step(a);
    end
    stat_clear = 0; in_valid = 0; out_ready = 1;
    repeat (3) step(a);
    // reset while full and stalled
    out_ready = 0; in_valid = 1; drive_add(8'h80, 8'h80);
    repeat (2) step(a);
    rst_n = 0;
    step(a);
    rst_n = 1; in_valid = 0;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst ovf_count", ovf_count, 0);
    chk("rst ovf_sticky", ovf_sticky, 0);
    out_ready = 1;
    repeat (4) step(a);
    chk("queue drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
